// File: rtl/keypad_digit_entry_pkg.sv
// Shared types and seven-segment lookup for the keypad digit-entry block.
package keypad_pkg;

  typedef enum logic [1:0] {
    KD_IDLE,
    KD_PRESS_WAIT,
    KD_HELD,
    KD_REL_WAIT
  } kd_state_t;

  // Segment order is {g,f,e,d,c,b,a}; decimal point is handled by the caller.
  localparam logic [6:0] SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] value);
    return SEG7[value];
  endfunction

endpackage

// File: rtl/keypad_digit_entry_if.sv
// Key inputs and display/buffer outputs of the keypad digit-entry block.
interface keypad_digit_entry_if #(
  parameter int NKEYS  = 16,
  parameter int DIGITS = 8
);

  logic [NKEYS-1:0]    keys;
  logic                bksp;
  logic                clr;
  logic [4*DIGITS-1:0] digits;
  logic [8*DIGITS-1:0] seg;
  logic [3:0]          count;
  logic                full;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                overflow;

  modport master (
    output keys, bksp, clr,
    input  digits, seg, count, full, key_valid, key_code, overflow
  );

  modport slave (
    input  keys, bksp, clr,
    output digits, seg, count, full, key_valid, key_code, overflow
  );

endinterface

// File: rtl/keypad_digit_entry_prienc.sv
// NKEYS-to-4 priority encoder; the highest set key index wins.
module prienc_n #(
  parameter int NKEYS = 16
) (
  input  logic [NKEYS-1:0] keys,
  output logic [3:0]       code,
  output logic             strobe
);

  always_comb begin
    code = 4'h0;
    for (int i = 0; i < NKEYS; i++) begin
      if (keys[i]) code = 4'(i);
    end
    strobe = |keys;
  end

endmodule

// File: rtl/keypad_digit_entry.sv
// Debounced keypad entry into a shifting hex digit buffer with backspace,
// clear and seven-segment outputs with leading-digit blanking.
module keypad_digit_entry
  import keypad_pkg::*;
#(
  parameter int NKEYS     = 16,
  parameter int DIGITS    = 8,
  parameter int DEBOUNCE  = 2,
  parameter int OVERWRITE = 0
) (
  input logic                  hz100,
  input logic                  reset,
  keypad_digit_entry_if.slave  bus
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [3:0]    raw_code;
  logic          raw_strobe;
  kd_state_t     state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    cand, cand_next;
  logic          commit;

  logic [DW-1:0] digits_r;
  logic [3:0]    count_r;
  logic [3:0]    key_code_r;
  logic          key_valid_r;
  logic          overflow_r;
  logic          bksp_q, clr_q;
  logic          bksp_rise, clr_rise;
  logic          full_w;

  prienc_n #(.NKEYS(NKEYS)) u_prienc (
    .keys   (bus.keys),
    .code   (raw_code),
    .strobe (raw_strobe)
  );

  always_ff @(posedge hz100) begin
    if (reset) begin
      state <= KD_IDLE;
      cnt   <= '0;
      cand  <= 4'h0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      cand  <= cand_next;
    end
  end

  // Code changes while held are ignored; only a full release re-arms the FSM.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    cand_next  = cand;
    commit     = 1'b0;
    case (state)
      KD_IDLE: begin
        if (raw_strobe) begin
          cand_next  = raw_code;
          cnt_next   = CW'(1);
          next_state = KD_PRESS_WAIT;
        end
      end
      KD_PRESS_WAIT: begin
        if (!raw_strobe || raw_code != cand) begin
          cnt_next   = '0;
          next_state = KD_IDLE;
        end else if (cnt == CNT_LAST) begin
          commit     = 1'b1;
          cnt_next   = '0;
          next_state = KD_HELD;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      KD_HELD: begin
        if (!raw_strobe) begin
          cnt_next   = CW'(1);
          next_state = KD_REL_WAIT;
        end
      end
      KD_REL_WAIT: begin
        if (raw_strobe) begin
          cnt_next   = '0;
          next_state = KD_HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          next_state = KD_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: next_state = KD_IDLE;
    endcase
  end

  assign bksp_rise = bus.bksp & ~bksp_q;
  assign clr_rise  = bus.clr & ~clr_q;
  assign full_w    = (count_r == 4'(DIGITS));

  // clr beats bksp beats commit; a dropped commit still reports its key.
  always_ff @(posedge hz100) begin
    if (reset) begin
      digits_r    <= '0;
      count_r     <= 4'h0;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      bksp_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      bksp_q      <= bus.bksp;
      clr_q       <= bus.clr;
      key_valid_r <= commit;
      overflow_r  <= 1'b0;
      if (commit) key_code_r <= cand;
      if (clr_rise) begin
        digits_r <= '0;
        count_r  <= 4'h0;
      end else if (bksp_rise) begin
        if (count_r != 4'h0) begin
          digits_r <= digits_r >> 4;
          count_r  <= count_r - 4'd1;
        end
      end else if (commit) begin
        if (!full_w) begin
          digits_r <= DW'({digits_r, cand});
          count_r  <= count_r + 4'd1;
        end else if (OVERWRITE != 0) begin
          digits_r <= DW'({digits_r, cand});
        end else begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  assign bus.digits    = digits_r;
  assign bus.count     = count_r;
  assign bus.full      = full_w;
  assign bus.key_valid = key_valid_r;
  assign bus.key_code  = key_code_r;
  assign bus.overflow  = overflow_r;

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign bus.seg[8*i+7:8*i] = (4'(i) < count_r)
                              ? {1'b0, hex_to_seg7(digits_r[4*i+3:4*i])}
                              : 8'h00;
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry: one reject-when-full and one
// overwrite-when-full instance driven in lockstep, checked against a model.
module tb_keypad_digit_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic        bksp;
  logic        clr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] dig0;
    logic [3:0]  cnt0;
    logic        ovf0;
    logic [31:0] dig1;
    logic [3:0]  cnt1;
    logic [3:0]  code;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_dig0, m_dig1;
  logic [3:0]  m_cnt0, m_cnt1;

  keypad_digit_entry_if #(.NKEYS(16), .DIGITS(8)) bus0 ();
  keypad_digit_entry_if #(.NKEYS(16), .DIGITS(8)) bus1 ();

  assign bus0.keys = keys;
  assign bus0.bksp = bksp;
  assign bus0.clr  = clr;
  assign bus1.keys = keys;
  assign bus1.bksp = bksp;
  assign bus1.clr  = clr;

  keypad_digit_entry #(.NKEYS(16), .DIGITS(8), .DEBOUNCE(2), .OVERWRITE(0)) dut0 (
    .hz100 (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  keypad_digit_entry #(.NKEYS(16), .DIGITS(8), .DEBOUNCE(2), .OVERWRITE(1)) dut1 (
    .hz100 (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dig0 = 32'h0; m_cnt0 = 4'h0;
    m_dig1 = 32'h0; m_cnt1 = 4'h0;
  endtask

  // Pushes the expected post-commit buffer state for both instances.
  task automatic expect_commit(input logic [3:0] code);
    exp_t e;
    e.ovf0 = 1'b0;
    if (m_cnt0 < 4'd8) begin
      m_dig0 = {m_dig0[27:0], code};
      m_cnt0 = m_cnt0 + 4'd1;
    end else begin
      e.ovf0 = 1'b1;
    end
    m_dig1 = {m_dig1[27:0], code};
    if (m_cnt1 < 4'd8) m_cnt1 = m_cnt1 + 4'd1;
    e.dig0 = m_dig0; e.cnt0 = m_cnt0;
    e.dig1 = m_dig1; e.cnt1 = m_cnt1;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic check_commit();
    exp_t e;
    check("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("commit_digits0", bus0.digits, e.dig0);
      check("commit_count0", bus0.count, e.cnt0);
      check("commit_ovf0", bus0.overflow, e.ovf0);
      check("commit_code0", bus0.key_code, e.code);
      check("commit_digits1", bus1.digits, e.dig1);
      check("commit_count1", bus1.count, e.cnt1);
      check("commit_ovf1", bus1.overflow, 1'b0);
    end
  endtask

  task automatic press(input logic [15:0] k, input logic [3:0] code);
    expect_commit(code);
    keys = k;
    tick();
    check("kv_early", bus0.key_valid, 1'b0);
    tick();
    check("kv_commit0", bus0.key_valid, 1'b1);
    check("kv_commit1", bus1.key_valid, 1'b1);
    check_commit();
  endtask

  task automatic release_keys();
    keys = 16'h0;
    tick();
    check("kv_pulse", bus0.key_valid, 1'b0);
    check("ovf_pulse", bus0.overflow, 1'b0);
    tick();
    tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    model_reset();
  endtask

  initial begin
    reset = 1'b1; keys = 16'h0; bksp = 1'b0; clr = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    check("rst_digits", bus0.digits, 32'h0);
    check("rst_count", bus0.count, 4'h0);
    check("rst_seg", bus0.seg, 64'h0);
    check("rst_full", bus0.full, 1'b0);
    check("rst_kv", bus0.key_valid, 1'b0);
    check("rst_code", bus0.key_code, 4'h0);
    check("rst_ovf", bus0.overflow, 1'b0);
    tick();

    $display("[TB] bounce on key 5");
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      tick();
      check("bounce_kv", bus0.key_valid, 1'b0);
    end
    keys = 16'h0; tick(); tick();
    check("bounce_count", bus0.count, 4'h0);

    $display("[TB] single key 2");
    press(16'h0004, 4'h2);
    check("k2_seg0", bus0.seg[7:0], 8'h5B);
    check("k2_seg1", bus0.seg[15:8], 8'h00);
    check("k2_full", bus0.full, 1'b0);
    release_keys();

    $display("[TB] multi-key priority and held code change");
    press(16'h8101, 4'hF);
    keys = 16'h0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_kv", bus0.key_valid, 1'b0);
      check("held_code", bus0.key_code, 4'hF);
    end
    check("held_count", bus0.count, 4'h2);
    release_keys();

    $display("[TB] fill buffer then overflow");
    pulse_clr();
    check("clr_count", bus0.count, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      press(16'h1 << k, 4'(k));
      release_keys();
    end
    check("fill_full0", bus0.full, 1'b1);
    check("fill_seg7", bus0.seg[63:56], 8'h06);
    press(16'h0200, 4'h9);
    check("ovf_digits0", bus0.digits, 32'h12345678);
    check("ovf_full0", bus0.full, 1'b1);
    check("ovw_digits1", bus1.digits, 32'h23456789);
    check("ovw_count1", bus1.count, 4'd8);
    release_keys();

    $display("[TB] backspace and clear");
    pulse_clr();
    bksp = 1'b1; tick(); bksp = 1'b0; tick();
    check("bksp_empty_count", bus0.count, 4'h0);
    press(16'h0400, 4'hA); release_keys();
    press(16'h0800, 4'hB); release_keys();
    press(16'h1000, 4'hC); release_keys();
    bksp = 1'b1; tick();
    check("bksp_count", bus0.count, 4'd2);
    check("bksp_digits", bus0.digits, 32'h000000AB);
    check("bksp_seg", bus0.seg[23:0], 24'h00777C);
    bksp = 1'b0; tick();
    bksp = 1'b1; clr = 1'b1; tick();
    check("both_count", bus0.count, 4'h0);
    check("both_digits", bus0.digits, 32'h0);
    bksp = 1'b0; clr = 1'b0; tick();
    model_reset();

    $display("[TB] reset during press");
    keys = 16'h0008;
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_digits", bus0.digits, 32'h0);
    check("rst_mid_seg", bus0.seg, 64'h0);
    check("rst_mid_kv", bus0.key_valid, 1'b0);
    check("rst_mid_code", bus0.key_code, 4'h0);
    reset = 1'b0;
    model_reset();
    press(16'h0008, 4'h3);
    release_keys();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_digit_entry.md
# keypad_digit_entry

Parametrised keypad-entry block: priority-encodes NKEYS push-buttons, debounces the encoded key with a press/release state machine, and shifts each accepted key code as a hex digit into a DIGITS-deep digit buffer with backspace and clear. The buffer drives DIGITS seven-segment outputs with leading-digit blanking. It sits between the `pb` inputs and `ss7`..`ss0` in `top`, and replaces the purely combinational encoder-to-display path with a numeric entry register.

## Interface
- NKEYS, 16: number of key inputs; 2..16. Code width is 4 bits fixed.
- DIGITS, 8: digit buffer depth and display count; 1..8.
- DEBOUNCE, 2: consecutive identical samples required to accept a press or a release; ≥2.
- OVERWRITE, 0: 1 = entry when full discards the oldest digit; 0 = entry when full is rejected.

- hz100  in  1  system clock
- reset  in  1  synchronous, active-high reset
- keys  in  NKEYS  raw key levels; highest index wins
- bksp  in  1  backspace level; acts on rising edge
- clr  in  1  clear level; acts on rising edge
- digits  out  4*DIGITS  buffer; digit 0 (newest) in [3:0]
- seg  out  8*DIGITS  segment patterns {dp, g..a} per digit; digit i in [8i+7:8i]
- count  out  4  valid digits, 0..DIGITS
- full  out  1  count == DIGITS
- key_valid  out  1  one-cycle pulse on accepted press
- key_code  out  4  code of last accepted key
- overflow  out  1  one-cycle pulse on a rejected entry (OVERWRITE=0 only)

## Operation
- Encoder, combinational: raw_code = highest set index of keys; raw_strobe = |keys.
- Debounce FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT. Counter cnt is 0..DEBOUNCE-1.
  - IDLE: on raw_strobe, latch cand = raw_code, set cnt=1, and go to PRESS_WAIT.
  - PRESS_WAIT: if !raw_strobe or raw_code != cand, go to IDLE. Else if cnt == DEBOUNCE-1, commit and go to HELD. Else cnt++.
  - HELD: on !raw_strobe, set cnt=1 and go to REL_WAIT. A change of key code while held is ignored.
  - REL_WAIT: on raw_strobe, go to HELD (bounce). Else if cnt == DEBOUNCE-1, go to IDLE. Else cnt++.
- Commit: key_code ← cand and key_valid=1.
  - If count<DIGITS: digits ← {digits[4*DIGITS-5:0], cand} and count++.
  - If full and OVERWRITE=1: shift as above; count stays at DIGITS.
  - If full and OVERWRITE=0: buffer unchanged; overflow=1; key_valid still pulses.
- Backspace, on a rising edge of bksp with count>0: digits ← {4'h0, digits[4*DIGITS-1:4]} and count--. With count=0 it is a no-op.
- Clear, on a rising edge of clr: digits ← 0 and count ← 0. The FSM is not affected.
- Same-cycle precedence: reset > clr > bksp > commit. The lower-priority event in that cycle is dropped; key_valid still pulses on a dropped commit.
- Display:
  - seg[8i+6:8i] = hex pattern of digits[4i+3:4i] if i < count, else 0.
  - dp = 0 always.
  - Hex patterns are 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:67, A:77, B:7C, C:39, D:5E, E:79, F:71.

## Timing
- All state changes occur on the rising edge of hz100. seg and full are combinational from registers.
- Press latency: a key sampled identical at edges 0..DEBOUNCE-1 commits at edge DEBOUNCE-1. digits, count, key_valid and key_code are valid after that edge.
- key_valid and overflow are registered, one cycle wide.
- A bksp or clr rising edge sampled at edge t takes effect at edge t. The edge detectors are held at 0 on reset.
- Reset values: FSM IDLE, cnt 0, digits 0, count 0, key_code 0, key_valid 0, overflow 0, edge registers 0. Consequently seg is all 0 and full is 0.
- Reset mid-press: FSM returns to IDLE. A key still held after reset re-arms and needs a full DEBOUNCE window to commit.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum (kd_state_t);
  - the 16-entry SEG7 constant and the function hex_to_seg7.
- Sub-module prienc_n: parametrised NKEYS-to-4 priority encoder with strobe, purely combinational.
- Top of block: FSM, buffer, edge detectors, and a generate loop over DIGITS for seg.

## Test plan
- keys=16'h0004 held 2 cycles (DEBOUNCE=2), then released 2 cycles → one key_valid pulse, key_code=2, digits[3:0]=2, count=1, seg[6:0]=7'h5B, seg[15:8]=0.
- keys toggling 0→1→0→1 on bit 5 each cycle for 6 cycles → no key_valid, count=0, FSM never leaves IDLE/PRESS_WAIT.
- keys=16'h8101 held → code F accepted, and the code stays F when bit 15 drops and bit 8 remains (held, no new commit).
- Enter 8 keys 1..8, then key 9, with OVERWRITE=0 → digits=32'h12345678, full=1, overflow pulse, key_valid pulse. Repeat with OVERWRITE=1 → digits=32'h23456789.
- Enter 3 digits, then pulse bksp → count=2, digits shifted right. Then bksp and clr asserted in the same cycle → count=0, digits=0.
- Assert reset during PRESS_WAIT with the key held → all outputs 0. key_valid fires DEBOUNCE-1 edges after reset deasserts.
